// File: rtl/seq_abc_gen_if.sv
// Interface bundling the burst request and the a/b/c sequence outputs of seq_abc_gen.
// err_inj exists only when SEQ_ABC_GEN_ERR_INJ_EN is defined.
interface seq_abc_gen_if #(
    parameter int REP_W = 8,
    parameter int GAP_W = 4
);
    logic             start;
    logic [REP_W-1:0] n_reps;
    logic [GAP_W-1:0] gap;
`ifdef SEQ_ABC_GEN_ERR_INJ_EN
    logic             err_inj;
`endif
    logic             a;
    logic             b;
    logic             c;
    logic             busy;
    logic             done;
    logic [REP_W-1:0] rep_cnt;

`ifdef SEQ_ABC_GEN_ERR_INJ_EN
    modport master (output start, n_reps, gap, err_inj,
                    input  a, b, c, busy, done, rep_cnt);
    modport slave  (input  start, n_reps, gap, err_inj,
                    output a, b, c, busy, done, rep_cnt);
`else
    modport master (output start, n_reps, gap,
                    input  a, b, c, busy, done, rep_cnt);
    modport slave  (input  start, n_reps, gap,
                    output a, b, c, busy, done, rep_cnt);
`endif
endinterface

// File: rtl/seq_abc_gen.sv
// Burst generator: n_reps a->b->c one-cycle pulse triplets separated by gap idle cycles.
// Optional SEQ_ABC_GEN_ERR_INJ_EN: captured err_inj suppresses c of the final triplet.
module seq_abc_gen #(
    parameter int REP_W = 8,
    parameter int GAP_W = 4
) (
    input  logic          clk,
    input  logic          rst,
    seq_abc_gen_if.slave  bus
);
    typedef enum logic [2:0] {
        IDLE = 3'd0,
        PH_A = 3'd1,
        PH_B = 3'd2,
        PH_C = 3'd3,
        GAP  = 3'd4,
        FIN  = 3'd5
    } state_e;

    localparam logic [REP_W-1:0] REP_ONE = {{(REP_W-1){1'b0}}, 1'b1};
    localparam logic [GAP_W-1:0] GAP_ONE = {{(GAP_W-1){1'b0}}, 1'b1};

    state_e           state;
    state_e           next;
    logic [REP_W-1:0] n_reps_q;
    logic [GAP_W-1:0] gap_q;
    logic [GAP_W-1:0] gap_cnt;
    logic [REP_W-1:0] rep_cnt;
    logic             a_q;
    logic             b_q;
    logic             c_q;
    logic             busy_q;
    logic             done_q;
    logic             capture;
    logic             rep_inc;
    logic             gap_load;
    logic             last;
    logic             c_kill;

    // rep_cnt never exceeds n_reps-1 while a triplet runs, so +1 cannot wrap here.
    assign last = ((rep_cnt + REP_ONE) == n_reps_q);

`ifdef SEQ_ABC_GEN_ERR_INJ_EN
    logic err_q;
    assign c_kill = err_q && last;
`else
    assign c_kill = 1'b0;
`endif

    always_comb begin
        next     = state;
        capture  = 1'b0;
        rep_inc  = 1'b0;
        gap_load = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    capture = 1'b1;
                    next    = (bus.n_reps == '0) ? FIN : PH_A;
                end
            end
            PH_A: next = PH_B;
            PH_B: next = PH_C;
            PH_C: begin
                rep_inc = 1'b1;
                if (last) begin
                    next = FIN;
                end else if (gap_q != '0) begin
                    next     = GAP;
                    gap_load = 1'b1;
                end else begin
                    next = PH_A;
                end
            end
            GAP: begin
                if (gap_cnt == '0) begin
                    next = PH_A;
                end
            end
            FIN:     next = IDLE;
            default: next = IDLE;
        endcase
    end

    // Outputs are registered from the next state so they line up with the state they decode.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            n_reps_q <= '0;
            gap_q    <= '0;
            gap_cnt  <= '0;
            rep_cnt  <= '0;
            a_q      <= 1'b0;
            b_q      <= 1'b0;
            c_q      <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
`ifdef SEQ_ABC_GEN_ERR_INJ_EN
            err_q    <= 1'b0;
`endif
        end else begin
            state  <= next;
            a_q    <= (next == PH_A);
            b_q    <= (next == PH_B);
            c_q    <= (next == PH_C) && !c_kill;
            busy_q <= (next != IDLE);
            done_q <= (next == FIN);
            if (capture) begin
                n_reps_q <= bus.n_reps;
                gap_q    <= bus.gap;
                rep_cnt  <= '0;
`ifdef SEQ_ABC_GEN_ERR_INJ_EN
                err_q    <= bus.err_inj;
`endif
            end else if (rep_inc) begin
                rep_cnt <= rep_cnt + REP_ONE;
            end
            // gap_cnt holds the GAP cycles still to go after the current one.
            if (gap_load) begin
                gap_cnt <= gap_q - GAP_ONE;
            end else if (state == GAP) begin
                gap_cnt <= gap_cnt - GAP_ONE;
            end
        end
    end

    assign bus.a       = a_q;
    assign bus.b       = b_q;
    assign bus.c       = c_q;
    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.rep_cnt = rep_cnt;
endmodule

// File: tb/tb_seq_abc_gen.sv
// Scoreboard bench for seq_abc_gen: each accepted burst pushes its expected per-cycle trace,
// a negedge monitor pops and compares every cycle (idle cycles expect held rep_cnt).
module tb_seq_abc_gen;
    localparam int REP_W = 8;
    localparam int GAP_W = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    seq_abc_gen_if #(.REP_W(REP_W), .GAP_W(GAP_W)) bus ();
    seq_abc_gen #(.REP_W(REP_W), .GAP_W(GAP_W)) dut (.clk(clk), .rst(rst), .bus(bus));

    typedef struct packed {
        logic             a;
        logic             b;
        logic             c;
        logic             busy;
        logic             done;
        logic [REP_W-1:0] rep;
    } obs_t;

    obs_t             exp_q[$];
    logic [REP_W-1:0] last_rep = '0;
    int               n_checks = 0;
    int               n_fail   = 0;

    // Expected trace of one burst, one entry per cycle from the cycle after the start edge.
    function automatic void build(input int n, input int g, input bit inj);
        for (int r = 0; r < n; r++) begin
            exp_q.push_back('{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, REP_W'(r)});
            exp_q.push_back('{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, REP_W'(r)});
            exp_q.push_back('{1'b0, 1'b0, !(inj && r == n - 1), 1'b1, 1'b0, REP_W'(r)});
            if (r < n - 1) begin
                for (int k = 0; k < g; k++)
                    exp_q.push_back('{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, REP_W'(r + 1)});
            end
        end
        exp_q.push_back('{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, REP_W'(n)});
    endfunction

    always @(negedge clk) begin
        obs_t act;
        obs_t exp;
        act = '{bus.a, bus.b, bus.c, bus.busy, bus.done, bus.rep_cnt};
        if (rst === 1'b1) begin
            exp_q.delete();
            last_rep = '0;
            exp = '0;
        end else if (exp_q.size() > 0) begin
            exp = exp_q.pop_front();
            last_rep = exp.rep;
        end else begin
            exp = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, last_rep};
        end
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL cycle_out t=%0t actual a=%b b=%b c=%b busy=%b done=%b rep=%0d required a=%b b=%b c=%b busy=%b done=%b rep=%0d",
                     $time, act.a, act.b, act.c, act.busy, act.done, act.rep,
                     exp.a, exp.b, exp.c, exp.busy, exp.done, exp.rep);
        end
    end

    // Called at posedge+1 with the DUT idle; returns at posedge+1 after the start edge.
    task automatic issue(input int n, input int g, input bit inj);
        bus.start  = 1'b1;
        bus.n_reps = REP_W'(n);
        bus.gap    = GAP_W'(g);
`ifdef SEQ_ABC_GEN_ERR_INJ_EN
        bus.err_inj = inj;
`endif
        @(posedge clk);
        build(n, g, inj);
        #1;
        bus.start  = 1'b0;
        bus.n_reps = REP_W'($urandom);
        bus.gap    = GAP_W'($urandom);
`ifdef SEQ_ABC_GEN_ERR_INJ_EN
        bus.err_inj = 1'($urandom);
`endif
    endtask

    // Runs until the expected trace drains; optionally fires stray starts mid-burst.
    task automatic wait_done(input bit stray);
        int cyc = 0;
        while (exp_q.size() != 0 && cyc < 6000) begin
            if (stray && exp_q.size() > 3 && $urandom_range(0, 3) == 0) begin
                bus.start  = 1'b1;
                bus.n_reps = REP_W'($urandom_range(1, 9));
                bus.gap    = GAP_W'($urandom);
            end
            @(posedge clk);
            #1;
            bus.start = 1'b0;
            cyc++;
        end
        if (exp_q.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL burst_timeout actual %0d entries left required 0", exp_q.size());
        end
    endtask

    task automatic idle_cycles(input int k);
        for (int i = 0; i < k; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        bit inj;
        rst        = 1'b1;
        bus.start  = 1'b0;
        bus.n_reps = '0;
        bus.gap    = '0;
`ifdef SEQ_ABC_GEN_ERR_INJ_EN
        bus.err_inj = 1'b0;
`endif
        idle_cycles(3);
        rst = 1'b0;
        idle_cycles(2);

        issue(1, 0, 1'b0);  wait_done(1'b0);
        issue(3, 2, 1'b0);  wait_done(1'b0);
        issue(0, 3, 1'b0);  wait_done(1'b0);
        idle_cycles(2);

        // Stray start with n_reps=5 lands while the burst is in PH_B.
        issue(3, 1, 1'b0);
        idle_cycles(1);
        bus.start  = 1'b1;
        bus.n_reps = REP_W'(5);
        bus.gap    = GAP_W'(0);
        idle_cycles(1);
        bus.start  = 1'b0;
        wait_done(1'b0);

        // Reset during PH_B of the second triplet of four, then restart straight after release.
        issue(4, 1, 1'b0);
        @(posedge clk); @(posedge clk); @(posedge clk); @(posedge clk); @(posedge clk);
        #2;
        rst = 1'b1;
        idle_cycles(2);
        rst = 1'b0;
        issue(2, 0, 1'b0);  wait_done(1'b0);

`ifdef SEQ_ABC_GEN_ERR_INJ_EN
        issue(2, 0, 1'b1);  wait_done(1'b0);
        issue(2, 1, 1'b0);  wait_done(1'b0);
`endif

        for (int t = 0; t < 14; t++) begin
            inj = 1'b0;
`ifdef SEQ_ABC_GEN_ERR_INJ_EN
            inj = 1'($urandom_range(0, 1));
`endif
            issue($urandom_range(0, 5), $urandom_range(0, 3), inj);
            wait_done(1'b1);
            idle_cycles($urandom_range(0, 2));
        end

        issue(2, 15, 1'b0);   wait_done(1'b0);
        issue(255, 15, 1'b0); wait_done(1'b1);
        issue(255, 0, 1'b0);  wait_done(1'b0);
        idle_cycles(3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
